// File: rtl/dram_cycle_scheduler.sv
// dram_cycle_scheduler: RAS/CAS sequencer for the FastRAM DRAM array.
// Arbitrates decoded CPU accesses against CAS-before-RAS refresh with a
// refresh-debt counter; refresh is forced once the debt saturates.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   ACC_REQ, ACC_UDS, ACC_LDS   decoded RAM cycle and data strobes
//   RAS, UCAS, LCAS, MUX_COL    DRAM strobes and row/column mux select
//   ACC_ACK                     access is in its column phase
//   REF_BUSY                    refresh (incl. its precharge) in progress
//   DEBT, OVERRUN               refreshes owed, sticky lost-refresh flag
module dram_cycle_scheduler #(
    parameter int REFRESH_INTERVAL = 110,
    parameter int MAX_DEBT         = 8,
    parameter int TRP              = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ACC_REQ,
    input  logic       ACC_UDS,
    input  logic       ACC_LDS,
    output logic       RAS,
    output logic       UCAS,
    output logic       LCAS,
    output logic       MUX_COL,
    output logic       ACC_ACK,
    output logic       REF_BUSY,
    output logic [3:0] DEBT,
    output logic       OVERRUN
);

    localparam int TW = $clog2(REFRESH_INTERVAL + 1);

    typedef enum logic [2:0] {
        IDLE, REF_CAS, REF_RAS1, REF_RAS2, PRECHG, ACC_ROW, ACC_COL
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [2:0]      prc_q;
    logic            wrap, dec;
    logic            ras_d, ucas_d, lcas_d, mux_d, ack_d, busy_d;

    assign wrap = (timer_q == TW'(REFRESH_INTERVAL - 1));

    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (DEBT == 4'(MAX_DEBT))
                    state_d = REF_CAS;
                else if (ACC_REQ)
                    state_d = ACC_ROW;
                else if (DEBT != 4'd0)
                    state_d = REF_CAS;
            end
            REF_CAS:  state_d = REF_RAS1;
            REF_RAS1: state_d = REF_RAS2;
            REF_RAS2: begin
                state_d = PRECHG;
                dec     = 1'b1;
            end
            PRECHG: begin
                if (prc_q == 3'(TRP - 1))
                    state_d = IDLE;
            end
            ACC_ROW:  state_d = ACC_COL;
            ACC_COL: begin
                if (!ACC_REQ)
                    state_d = PRECHG;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        ras_d  = 1'b0;
        ucas_d = 1'b0;
        lcas_d = 1'b0;
        mux_d  = 1'b0;
        ack_d  = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            REF_CAS: begin
                ucas_d = 1'b1;
                lcas_d = 1'b1;
                busy_d = 1'b1;
            end
            REF_RAS1, REF_RAS2: begin
                ras_d  = 1'b1;
                ucas_d = 1'b1;
                lcas_d = 1'b1;
                busy_d = 1'b1;
            end
            // Precharge only counts as refresh when a refresh led into it.
            PRECHG: begin
                busy_d = (state_q == PRECHG) ? REF_BUSY
                                             : (state_q == REF_RAS2);
            end
            ACC_ROW: ras_d = 1'b1;
            // CAS latches on the first sampled strobe; an access that
            // dropped during the row phase gets a CAS-less column clock.
            ACC_COL: begin
                ras_d  = 1'b1;
                mux_d  = 1'b1;
                ack_d  = 1'b1;
                ucas_d = ACC_REQ &
                         (ACC_UDS | ((state_q == ACC_COL) & UCAS));
                lcas_d = ACC_REQ &
                         (ACC_LDS | ((state_q == ACC_COL) & LCAS));
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            prc_q    <= '0;
            DEBT     <= '0;
            OVERRUN  <= 1'b0;
            RAS      <= 1'b0;
            UCAS     <= 1'b0;
            LCAS     <= 1'b0;
            MUX_COL  <= 1'b0;
            ACC_ACK  <= 1'b0;
            REF_BUSY <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= wrap ? '0 : timer_q + 1'b1;
            prc_q    <= (state_q == PRECHG) ? prc_q + 3'd1 : 3'd0;
            RAS      <= ras_d;
            UCAS     <= ucas_d;
            LCAS     <= lcas_d;
            MUX_COL  <= mux_d;
            ACC_ACK  <= ack_d;
            REF_BUSY <= busy_d;
            // A wrap coinciding with a completed refresh cancels out.
            if (wrap && !dec) begin
                if (DEBT == 4'(MAX_DEBT))
                    OVERRUN <= 1'b1;
                else
                    DEBT <= DEBT + 4'd1;
            end else if (dec && !wrap) begin
                DEBT <= DEBT - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dram_cycle_scheduler.sv
// tb_dram_cycle_scheduler: directed + randomized bench for the DRAM
// scheduler, checked cycle by cycle against a behavioural model.
module tb_dram_cycle_scheduler;

    localparam int RI   = 110;
    localparam int MAXD = 8;
    localparam int TRPC = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ACC_REQ = 1'b0;
    logic       ACC_UDS = 1'b0;
    logic       ACC_LDS = 1'b0;
    logic       RAS, UCAS, LCAS, MUX_COL, ACC_ACK, REF_BUSY, OVERRUN;
    logic [3:0] DEBT;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dram_cycle_scheduler #(
        .REFRESH_INTERVAL(RI),
        .MAX_DEBT(MAXD),
        .TRP(TRPC)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ACC_REQ(ACC_REQ),
        .ACC_UDS(ACC_UDS),
        .ACC_LDS(ACC_LDS),
        .RAS(RAS),
        .UCAS(UCAS),
        .LCAS(LCAS),
        .MUX_COL(MUX_COL),
        .ACC_ACK(ACC_ACK),
        .REF_BUSY(REF_BUSY),
        .DEBT(DEBT),
        .OVERRUN(OVERRUN)
    );

    // Model: kind 0 idle, 1 refresh (cyc = clocks since start),
    // 2 access (col phase flag, pre = precharge clocks or -1).
    int m_timer, m_debt, m_kind, m_cyc, m_pre;
    bit m_ovr, m_col, m_abort, m_u, m_l;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {5'd0, RAS, UCAS, LCAS, MUX_COL, ACC_ACK, REF_BUSY,
                DEBT, OVERRUN};
    endfunction

    function automatic logic [15:0] model_vec();
        bit r, u, l, mx, ak, bz;
        r = 0; u = 0; l = 0; mx = 0; ak = 0; bz = 0;
        if (m_kind == 1) begin
            bz = 1;
            if (m_cyc == 0) begin
                u = 1; l = 1;
            end else if (m_cyc <= 2) begin
                r = 1; u = 1; l = 1;
            end
        end else if (m_kind == 2 && m_pre < 0) begin
            r = 1;
            if (m_col) begin
                mx = 1; ak = 1; u = m_u; l = m_l;
            end
        end
        return {5'd0, r, u, l, mx, ak, bz, 4'(m_debt), m_ovr};
    endfunction

    task automatic model_edge(input bit rst, input bit req,
                              input bit uds, input bit lds);
        bit wrap, dec;
        int od;
        if (rst) begin
            m_timer = 0; m_debt = 0; m_kind = 0; m_cyc = 0;
            m_pre = -1; m_ovr = 0; m_col = 0; m_abort = 0;
            m_u = 0; m_l = 0;
            return;
        end
        wrap = (m_timer == RI - 1);
        m_timer = wrap ? 0 : m_timer + 1;
        dec = 0;
        od = m_debt;
        case (m_kind)
            0: begin
                if (od == MAXD || (!req && od > 0)) begin
                    m_kind = 1; m_cyc = 0;
                end else if (req) begin
                    m_kind = 2; m_col = 0; m_pre = -1;
                end
            end
            1: begin
                m_cyc++;
                if (m_cyc == 3) dec = 1;
                if (m_cyc == 3 + TRPC) m_kind = 0;
            end
            default: begin
                if (m_pre >= 0) begin
                    m_pre++;
                    if (m_pre == TRPC) m_kind = 0;
                end else if (!m_col) begin
                    m_col = 1; m_abort = !req;
                    m_u = req & uds; m_l = req & lds;
                end else if (!req || m_abort) begin
                    m_pre = 0;
                end else begin
                    m_u |= uds; m_l |= lds;
                end
            end
        endcase
        if (wrap && !dec) begin
            if (m_debt == MAXD) m_ovr = 1;
            else m_debt++;
        end else if (dec && !wrap) begin
            m_debt--;
        end
    endtask

    task automatic cyc(input bit rst, input bit req,
                       input bit uds, input bit lds);
        RESET = rst; ACC_REQ = req; ACC_UDS = uds; ACC_LDS = lds;
        @(posedge CLK);
        model_edge(rst, req, uds, lds);
        #1;
        check("outs", dut_vec(), model_vec());
    endtask

    initial begin
        int hold;
        bit req, u, l;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_state", dut_vec(), 16'd0);

        repeat (RI) cyc(0, 0, 0, 0);
        check("debt_110", 16'(DEBT), 16'd1);
        cyc(0, 0, 0, 0);
        check("ref_cas", {14'd0, UCAS, RAS}, 16'b10);
        cyc(0, 0, 0, 0);
        check("ref_ras", {14'd0, RAS, LCAS}, 16'b11);
        repeat (4) cyc(0, 0, 0, 0);
        check("ref_done", {11'd0, REF_BUSY, DEBT}, 16'd0);

        cyc(0, 1, 1, 0);
        check("acc_row", {13'd0, RAS, MUX_COL, ACC_ACK}, 16'b100);
        cyc(0, 1, 1, 0);
        check("acc_col", {12'd0, MUX_COL, ACC_ACK, UCAS, LCAS},
              16'b1110);
        repeat (2) cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        check("acc_rel", {13'd0, RAS, UCAS, MUX_COL}, 16'd0);
        repeat (3) cyc(0, 0, 0, 0);

        cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 1, 0, 0);
        check("late_pre", 16'(LCAS), 16'd0);
        cyc(0, 1, 0, 1);
        check("late_lds", 16'(LCAS), 16'd1);
        repeat (3) cyc(0, 1, 0, 0);
        check("late_hold", 16'(LCAS), 16'd1);
        repeat (3) cyc(0, 0, 0, 0);

        repeat (1100) cyc(0, 1, 1, 1);
        check("debt_sat", 16'(DEBT), 16'(MAXD));
        check("overrun", 16'(OVERRUN), 16'd1);
        repeat (60) cyc(0, 0, 0, 0);
        check("overrun_sticky", 16'(OVERRUN), 16'd1);

        cyc(1, 0, 0, 0);
        repeat (RI + 2) cyc(0, 0, 0, 0);
        check("in_ras1", {14'd0, RAS, REF_BUSY}, 16'b11);
        cyc(1, 0, 0, 0);
        check("rst_mid", dut_vec(), 16'd0);
        repeat (RI - 1) cyc(0, 0, 0, 0);
        check("debt_109", 16'(DEBT), 16'd0);
        cyc(0, 0, 0, 0);
        check("debt_again", 16'(DEBT), 16'd1);

        req = 0; u = 0; l = 0; hold = 3;
        repeat (4000) begin
            if (hold == 0) begin
                req = !req;
                if (req) begin
                    hold = $urandom_range(1, 12);
                    u = $urandom_range(0, 1) == 1;
                    l = $urandom_range(0, 1) == 1;
                end else begin
                    hold = $urandom_range(2, 15);
                    u = 0; l = 0;
                end
            end else begin
                hold--;
                if (req && $urandom_range(0, 3) == 0) u = 1;
                if (req && $urandom_range(0, 3) == 0) l = 1;
            end
            if ($urandom_range(0, 499) == 0) begin
                cyc(1, 0, 0, 0);
                req = 0; u = 0; l = 0; hold = 2;
            end else begin
                cyc(0, req, u, l);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
